jt51_exp_interp: RTL and testbench



---
 rtl/jt51_exp_pkg.sv | 29 ++
 rtl/jt51_exp_tbl.sv | 38 +++
 rtl/jt51_exp_interp.sv | 132 +++++++++++++
 tb/tb_jt51_exp_interp.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jt51_exp_pkg.sv
// jt51_exp_pkg: shared defaults and the exponent table generator
// for the log-to-linear interpolator.
package jt51_exp_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int FRAC_W_DEF  = 3;
  localparam int SHIFT_W_DEF = 4;
  localparam int OUT_W_DEF   = 13;
  localparam int CH_W_DEF    = 5;

  // T(i) = min(2^out_w-1, round(2^out_w * 2^(-i/2^addr_w)))
  function automatic int exp_tbl_val(
    input int i,
    input int addr_w,
    input int out_w
  );
    real v_full;
    real v_val;
    int  v_int;
    int  v_lim;
    v_full = 2.0 ** real'(out_w);
    v_val  = v_full *
      (2.0 ** (-real'(i) / real'(1 << addr_w)));
    v_int  = $rtoi(v_val + 0.5);
    v_lim  = (1 << out_w) - 1;
    return (v_int > v_lim) ? v_lim : v_int;
  endfunction

endpackage

// File: rtl/jt51_exp_tbl.sv
// jt51_exp_tbl: N+1 entry exponent mantissa ROM,
// two registered read ports sharing one enable.
import jt51_exp_pkg::*;

module jt51_exp_tbl #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [ADDR_W:0]   i_addr_a,
  input  logic [ADDR_W:0]   i_addr_b,
  output logic [OUT_W-1:0]  o_q_a,
  output logic [OUT_W-1:0]  o_q_b
);

  localparam int N = 1 << ADDR_W;

  logic [OUT_W-1:0] w_rom [0:N];
  logic [OUT_W-1:0] r_q_a;
  logic [OUT_W-1:0] r_q_b;

  for (genvar g = 0; g <= N; g++) begin : g_rom
    assign w_rom[g] = OUT_W'(exp_tbl_val(g, ADDR_W, OUT_W));
  end

  // Read both neighbours; hold while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_q_a <= w_rom[i_addr_a];
      r_q_b <= w_rom[i_addr_b];
    end
  end

  assign o_q_a = r_q_a;
  assign o_q_b = r_q_b;

endmodule

// File: rtl/jt51_exp_interp.sv
// jt51_exp_interp: 3-stage log attenuation to signed linear
// converter with table interpolation and valid/ready flow.
import jt51_exp_pkg::*;

module jt51_exp_interp #(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int FRAC_W  = FRAC_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int CH_W    = CH_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SHIFT_W+ADDR_W+FRAC_W-1:0]  in_att,
  input  logic                              in_sign,
  input  logic [CH_W-1:0]                   in_ch,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_W:0]                    out_lin,
  output logic [CH_W-1:0]                   out_ch
);

  localparam int ATT_W  = SHIFT_W + ADDR_W + FRAC_W;
  localparam int PROD_W = OUT_W + FRAC_W;

  logic                w_en;
  logic [SHIFT_W-1:0]  w_shift;
  logic [ADDR_W-1:0]   w_addr;
  logic [FRAC_W-1:0]   w_frac;
  logic [ADDR_W:0]     w_addr_a;
  logic [ADDR_W:0]     w_addr_b;

  logic [OUT_W-1:0]    w_ta;
  logic [OUT_W-1:0]    w_tb;
  logic [OUT_W-1:0]    w_diff;
  logic [PROD_W-1:0]   w_prod;
  logic [OUT_W-1:0]    w_y;
  logic [OUT_W-1:0]    w_m;
  logic [OUT_W:0]      w_lin;

  logic                r1_valid;
  logic [FRAC_W-1:0]   r1_frac;
  logic [SHIFT_W-1:0]  r1_shift;
  logic                r1_sign;
  logic [CH_W-1:0]     r1_ch;

  logic                r2_valid;
  logic [OUT_W-1:0]    r2_y;
  logic [SHIFT_W-1:0]  r2_shift;
  logic                r2_sign;
  logic [CH_W-1:0]     r2_ch;

  logic                r_out_valid;
  logic [OUT_W:0]      r_out_lin;
  logic [CH_W-1:0]     r_out_ch;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  assign w_shift  = in_att[ATT_W-1 -: SHIFT_W];
  assign w_addr   = in_att[FRAC_W +: ADDR_W];
  assign w_frac   = in_att[FRAC_W-1:0];
  assign w_addr_a = {1'b0, w_addr};
  assign w_addr_b = w_addr_a + (ADDR_W+1)'(1);

  jt51_exp_tbl #(
    .ADDR_W (ADDR_W),
    .OUT_W  (OUT_W)
  ) u_tbl (
    .clk      (clk),
    .i_en     (w_en),
    .i_addr_a (w_addr_a),
    .i_addr_b (w_addr_b),
    .o_q_a    (w_ta),
    .o_q_b    (w_tb)
  );

  // Stage valid bits and output register, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_lin   <= '0;
      r_out_ch    <= '0;
    end else if (w_en) begin
      r1_valid    <= in_valid;
      r2_valid    <= r1_valid;
      r_out_valid <= r2_valid;
      r_out_lin   <= w_lin;
      r_out_ch    <= r2_ch;
    end
  end

  // Stage 1/2 side data travelling with the table reads
  always_ff @(posedge clk) begin
    if (w_en) begin
      r1_frac  <= w_frac;
      r1_shift <= w_shift;
      r1_sign  <= in_sign;
      r1_ch    <= in_ch;
      r2_y     <= w_y;
      r2_shift <= r1_shift;
      r2_sign  <= r1_sign;
      r2_ch    <= r1_ch;
    end
  end

  // Linear interpolation between adjacent table entries
  always_comb begin
    w_diff = w_ta - w_tb;
    w_prod = {{FRAC_W{1'b0}}, w_diff} *
             {{OUT_W{1'b0}}, r1_frac};
    w_y    = w_ta - w_prod[PROD_W-1:FRAC_W];
  end

  // Octave shift with saturation to zero, then sign apply
  always_comb begin
    w_m = '0;
    if (32'(r2_shift) < OUT_W) begin
      w_m = r2_y >> r2_shift;
    end
    w_lin = r2_sign ? -{1'b0, w_m} : {1'b0, w_m};
  end

  assign out_valid = r_out_valid;
  assign out_lin   = r_out_lin;
  assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_jt51_exp_interp.sv
// tb_jt51_exp_interp: directed and random checks of the
// exponent interpolator against hand values and a model.
module tb_jt51_exp_interp;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_att;
  logic        in_sign;
  logic [4:0]  in_ch;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_lin;
  logic [4:0]  out_ch;

  int errs;
  int checks;
  int q_lin[$];
  int q_ch[$];

  jt51_exp_interp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_att    (in_att),
    .in_sign   (in_sign),
    .in_ch     (in_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lin   (out_lin),
    .out_ch    (out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string              tag,
    input logic signed [31:0] got,
    input logic signed [31:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mk(input int sh, input int a,
                                     input int f);
    return {4'(sh), 5'(a), 3'(f)};
  endfunction

  function automatic int tv(input int i);
    real v;
    int  r;
    v = 8192.0 * (2.0 ** (-real'(i) / 32.0));
    r = $rtoi(v + 0.5);
    return (r > 8191) ? 8191 : r;
  endfunction

  function automatic int model(input logic [11:0] att,
                               input logic sg);
    int sh, a, f, ta, tb, y, m;
    sh = int'(att[11:8]);
    a  = int'(att[7:3]);
    f  = int'(att[2:0]);
    ta = tv(a);
    tb = tv(a + 1);
    y  = ta - ((ta - tb) * f) / 8;
    m  = (sh >= 13) ? 0 : (y >> sh);
    return sg ? -m : m;
  endfunction

  task automatic run_one(input string tag, input logic [11:0] att,
                         input logic sg, input logic [4:0] ch,
                         input int exp);
    in_att   = att;
    in_sign  = sg;
    in_ch    = ch;
    in_valid = 1'b1;
    #1;
    check({tag, "_rdy"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    tick();
    check({tag, "_early"}, 32'(out_valid), 0);
    tick();
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_lin"}, 32'($signed(out_lin)), exp);
    check({tag, "_ch"}, 32'(out_ch), 32'(ch));
    tick();
  endtask

  initial begin
    int sent;
    int got;
    int n_in;
    int n_out;
    int done_cyc;
    logic was_held;
    logic [13:0] held;

    errs      = 0;
    checks    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_att    = '0;
    in_sign   = 1'b0;
    in_ch     = '0;
    out_ready = 1'b1;

    tick();
    tick();
    check("rst_ov", 32'(out_valid), 0);
    check("rst_lin", 32'(out_lin), 0);
    check("rst_ch", 32'(out_ch), 0);
    check("rst_rdy", 32'(in_ready), 1);
    rst_n = 1'b1;
    tick();

    run_one("a0", mk(0, 0, 0), 1'b0, 5'd3, 8191);
    run_one("a31f7", mk(0, 31, 7), 1'b0, 5'd4, 4108);
    run_one("a31s1", mk(1, 31, 7), 1'b0, 5'd5, 2054);
    run_one("a31s13", mk(13, 31, 7), 1'b0, 5'd6, 0);
    run_one("a31s15", mk(15, 31, 7), 1'b0, 5'd7, 0);
    run_one("neg1", mk(1, 0, 0), 1'b1, 5'd8, -4095);
    run_one("neg15", mk(15, 0, 0), 1'b1, 5'd9, 0);
    run_one("a16", mk(0, 16, 0), 1'b0, 5'd10, 5793);
    run_one("a0f4", mk(0, 0, 4), 1'b0, 5'd11, 8104);

    sent     = 0;
    got      = 0;
    was_held = 1'b0;
    held     = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 8);
      in_att    = mk(sent % 3, sent * 4, sent % 8);
      in_sign   = sent[0];
      in_ch     = 5'(8 + sent);
      #1;
      if (out_valid && !out_ready)
        check("bp_rdy", 32'(in_ready), 0);
      if (was_held)
        check("bp_hold", 32'(out_lin), 32'(held));
      was_held = out_valid && !out_ready;
      held     = out_lin;
      if (out_valid && out_ready) begin
        check("bp_nonempty", 32'(q_lin.size() > 0), 1);
        if (q_lin.size() > 0) begin
          check("bp_lin", 32'($signed(out_lin)), q_lin.pop_front());
          check("bp_ch", 32'(out_ch), q_ch.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q_lin.push_back(model(in_att, in_sign));
        q_ch.push_back(int'(in_ch));
        sent++;
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", got, 8);
    tick();
    tick();

    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_att   = mk(0, k, 0);
      in_sign  = 1'b0;
      in_ch    = 5'(20 + k);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_ov", 32'(out_valid), 0);
    check("mid_rdy", 32'(in_ready), 1);
    check("mid_lin", 32'(out_lin), 0);
    check("mid_ch", 32'(out_ch), 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("post_rst_ov", 32'(out_valid), 0);
    end
    run_one("post_rst", mk(0, 0, 0), 1'b0, 5'd7, 8191);

    q_lin.delete();
    q_ch.delete();
    n_in     = 0;
    n_out    = 0;
    done_cyc = 0;
    for (int cyc = 0; cyc < 60000 && n_out < 10000; cyc++) begin
      in_valid  = (n_in < 10000) && ($urandom_range(0, 3) != 0);
      in_att    = 12'($urandom);
      in_sign   = 1'($urandom);
      in_ch     = 5'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        check("rnd_nonempty", 32'(q_lin.size() > 0), 1);
        if (q_lin.size() > 0) begin
          check("rnd_lin", 32'($signed(out_lin)), q_lin.pop_front());
          check("rnd_ch", 32'(out_ch), q_ch.pop_front());
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        q_lin.push_back(model(in_att, in_sign));
        q_ch.push_back(int'(in_ch));
        n_in++;
      end
      done_cyc = cyc;
      tick();
    end
    in_valid = 1'b0;
    check("rnd_count", n_out, 10000);
    check("rnd_budget", 32'(done_cyc < 59999), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
